// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that funnels bytes from NREQ requesters into a uart
// transmitter over a UIBI master port, with optional per-requester packet lock.
module uart_tx_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] BAUD_DIV  = 32'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [8*NREQ-1:0]         req_data,
  input  logic [NREQ-1:0]           req_lock,
  output logic [NREQ-1:0]           req_ready,
  output logic                      bus_req,
  output logic                      bus_wen,
  output logic [31:0]               bus_addr,
  output logic [31:0]               bus_dat_o,
  input  logic [31:0]               bus_dat_i,
  input  logic                      bus_ready,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic [15:0]               tx_count
);

  localparam int unsigned IDW        = $clog2(NREQ);
  localparam logic [31:0] OFS_CTRL   = 32'h00;
  localparam logic [31:0] OFS_STATUS = 32'h04;
  localparam logic [31:0] OFS_BAUD   = 32'h08;
  localparam logic [31:0] OFS_TXDATA = 32'h0C;

  typedef enum logic [2:0] {INIT_CTRL, INIT_BAUD, IDLE, POLL, SEND} state_t;

  state_t             state, state_n;
  logic               bus_req_n, bus_wen_n;
  logic [31:0]        bus_addr_n, bus_dat_o_n;
  logic [7:0]         hold, hold_n;
  logic [IDW-1:0]     grant_id_n;
  logic [15:0]        tx_count_n;
  logic               owner_vld, owner_vld_n;
  logic [IDW-1:0]     owner_id, owner_id_n;

  logic               own_active, win_found, accept;
  logic [IDW-1:0]     win_id;
  int unsigned        cand;
  logic               acc_wen;
  logic [31:0]        acc_addr, acc_dat;
  logic               unused_bits;

  assign unused_bits = ^bus_dat_i[31:1];

  // Winner search: a live lock restricts the choice to the owner, else round-robin after grant_id.
  always_comb begin
    win_found  = 1'b0;
    win_id     = '0;
    cand       = 0;
    own_active = owner_vld && req_lock[owner_id];
    if (own_active) begin
      win_found = req_valid[owner_id];
      win_id    = owner_id;
    end else begin
      for (int unsigned i = 1; i <= NREQ; i++) begin
        cand = (32'(grant_id) + i) % NREQ;
        if (!win_found && req_valid[IDW'(cand)]) begin
          win_found = 1'b1;
          win_id    = IDW'(cand);
        end
      end
    end
  end

  assign accept    = (state == IDLE) && !rst && win_found;
  assign req_ready = accept ? (NREQ'(1) << win_id) : '0;
  assign busy      = rst || (state != IDLE);

  always_comb begin
    state_n     = state;
    bus_req_n   = bus_req;
    bus_wen_n   = bus_wen;
    bus_addr_n  = bus_addr;
    bus_dat_o_n = bus_dat_o;
    hold_n      = hold;
    grant_id_n  = grant_id;
    tx_count_n  = tx_count;
    owner_vld_n = owner_vld;
    owner_id_n  = owner_id;
    acc_wen     = 1'b1;
    acc_addr    = BASE_ADDR + OFS_CTRL;
    acc_dat     = 32'h1;

    case (state)
      INIT_BAUD: begin
        acc_addr = BASE_ADDR + OFS_BAUD;
        acc_dat  = BAUD_DIV;
      end
      POLL: begin
        acc_wen  = 1'b0;
        acc_addr = BASE_ADDR + OFS_STATUS;
        acc_dat  = '0;
      end
      SEND: begin
        acc_addr = BASE_ADDR + OFS_TXDATA;
        acc_dat  = {24'b0, hold};
      end
      default: ;
    endcase

    if (state == IDLE) begin
      if (owner_vld && !own_active) owner_vld_n = 1'b0;
      if (accept) begin
        hold_n      = req_data[{win_id, 3'b000} +: 8];
        grant_id_n  = win_id;
        owner_vld_n = req_lock[win_id];
        owner_id_n  = win_id;
        state_n     = POLL;
      end
    end else if (!bus_req) begin
      // bus_req is always low for the cycle after a completion, which gives the mandatory gap
      bus_req_n   = 1'b1;
      bus_wen_n   = acc_wen;
      bus_addr_n  = acc_addr;
      bus_dat_o_n = acc_dat;
    end else if (bus_ready) begin
      bus_req_n   = 1'b0;
      bus_wen_n   = 1'b0;
      bus_addr_n  = '0;
      bus_dat_o_n = '0;
      case (state)
        INIT_CTRL: state_n = (BAUD_DIV != 32'd0) ? INIT_BAUD : IDLE;
        INIT_BAUD: state_n = IDLE;
        POLL:      if (!bus_dat_i[0]) state_n = SEND;
        SEND: begin
          tx_count_n = tx_count + 16'd1;
          state_n    = IDLE;
        end
        default:   state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_CTRL;
      bus_req   <= 1'b0;
      bus_wen   <= 1'b0;
      bus_addr  <= '0;
      bus_dat_o <= '0;
      hold      <= '0;
      grant_id  <= '0;
      tx_count  <= '0;
      owner_vld <= 1'b0;
      owner_id  <= '0;
    end else begin
      state     <= state_n;
      bus_req   <= bus_req_n;
      bus_wen   <= bus_wen_n;
      bus_addr  <= bus_addr_n;
      bus_dat_o <= bus_dat_o_n;
      hold      <= hold_n;
      grant_id  <= grant_id_n;
      tx_count  <= tx_count_n;
      owner_vld <= owner_vld_n;
      owner_id  <= owner_id_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: init sequences, STATUS polling,
// round-robin rotation, packet lock and reset during a pending access.
module tb_uart_tx_arbiter;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_lock  = '0;
  logic [3:0]  req_ready;
  logic        bus_req, bus_wen, busy;
  logic [31:0] bus_addr, bus_dat_o, bus_dat_i;
  logic        bus_ready = 1'b0;
  logic [1:0]  grant_id;
  logic [15:0] tx_count;

  logic [3:0]  b_req_valid = '0;
  logic [31:0] b_req_data  = '0;
  logic [3:0]  b_req_lock  = '0;
  logic [3:0]  b_req_ready;
  logic        b_bus_req, b_bus_wen, b_busy;
  logic [31:0] b_bus_addr, b_bus_dat_o;
  logic [31:0] b_bus_dat_i = '0;
  logic        b_bus_ready = 1'b0;
  logic [1:0]  b_grant_id;
  logic [15:0] b_tx_count;

  uart_tx_arbiter #(.NREQ(4), .BASE_ADDR(BASE), .BAUD_DIV(32'd0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .bus_req(bus_req),
    .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_dat_o(bus_dat_o),
    .bus_dat_i(bus_dat_i), .bus_ready(bus_ready), .busy(busy),
    .grant_id(grant_id), .tx_count(tx_count)
  );

  uart_tx_arbiter #(.NREQ(4), .BASE_ADDR(BASE), .BAUD_DIV(32'd434)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_lock(b_req_lock), .req_ready(b_req_ready), .bus_req(b_bus_req),
    .bus_wen(b_bus_wen), .bus_addr(b_bus_addr), .bus_dat_o(b_bus_dat_o),
    .bus_dat_i(b_bus_dat_i), .bus_ready(b_bus_ready), .busy(b_busy),
    .grant_id(b_grant_id), .tx_count(b_tx_count)
  );

  // Slave models answer one cycle after request; STATUS reports busy until busy_until reads.
  logic [64:0] log_q[$];
  logic [64:0] b_log_q[$];
  logic [7:0]  tx_q[$];
  int          status_reads = 0;
  int          busy_until   = 0;
  int          gap_viol     = 0;
  int          pulse_viol   = 0;
  logic        done_prev    = 1'b0;
  logic [3:0]  ready_prev   = '0;

  assign bus_dat_i = (status_reads < busy_until) ? 32'h1 : 32'h0;

  always @(posedge clk) begin
    bus_ready <= bus_req && !bus_ready;
    if (bus_req && bus_ready) begin
      log_q.push_back({bus_wen, bus_addr, bus_dat_o});
      if (bus_wen && bus_addr == BASE + 32'hC) tx_q.push_back(bus_dat_o[7:0]);
      if (!bus_wen && bus_addr == BASE + 32'h4) status_reads <= status_reads + 1;
    end
    if (done_prev && bus_req) gap_viol <= gap_viol + 1;
    done_prev <= bus_req && bus_ready;
    if ((ready_prev & req_ready) != 4'b0) pulse_viol <= pulse_viol + 1;
    ready_prev <= req_ready;
  end

  always @(posedge clk) begin
    b_bus_ready <= b_bus_req && !b_bus_ready;
    if (b_bus_req && b_bus_ready) b_log_q.push_back({b_bus_wen, b_bus_addr, b_bus_dat_o});
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input bit which, input string tag);
    int n = 0;
    @(negedge clk);
    while ((which ? b_busy : busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(which ? b_busy : busy), 32'd0);
  endtask

  task automatic wait_grant(input logic [3:0] exp, input string tag);
    int n = 0;
    #1;
    while (req_ready == 4'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_grant"}, 32'(req_ready), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_idle(1'b0, "reinit");
    wait_idle(1'b1, "reinit_b");
  endtask

  int          base, base_tx, n;
  logic [64:0] e;

  initial begin
    // Reset state, with all requesters asserting valid
    req_valid = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_txcnt", 32'(tx_count), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    wait_idle(1'b0, "init");
    wait_idle(1'b1, "init_b");

    // Init without BAUD write
    check("init_nacc", 32'(log_q.size()), 32'd1);
    e = log_q[0];
    check("init_wen", 32'(e[64]), 32'd1);
    check("init_addr", e[63:32], BASE);
    check("init_data", e[31:0], 32'h1);

    // Init with BAUD write
    check("initb_nacc", 32'(b_log_q.size()), 32'd2);
    e = b_log_q[0];
    check("initb_ctrl_addr", e[63:32], BASE);
    check("initb_ctrl_data", e[31:0], 32'h1);
    e = b_log_q[1];
    check("initb_baud_addr", e[63:32], BASE + 32'h8);
    check("initb_baud_data", e[31:0], 32'd434);

    // Single byte from requester 2 with two busy STATUS replies
    base = log_q.size();
    busy_until = status_reads + 2;
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    wait_grant(4'b0100, "single");
    @(negedge clk);
    req_valid = '0;
    wait_idle(1'b0, "single");
    check("single_nacc", 32'(log_q.size() - base), 32'd4);
    for (int k = 0; k < 3; k++) begin
      e = log_q[base + k];
      check("single_poll_addr", e[63:32], BASE + 32'h4);
      check("single_poll_rd", {e[64], e[31:1]}, 32'd0);
    end
    e = log_q[base + 3];
    check("single_tx_addr", e[63:32], BASE + 32'hC);
    check("single_tx_data", e[31:0], 32'h0000_00A5);
    check("single_txcnt", 32'(tx_count), 32'd1);
    check("single_grant", 32'(grant_id), 32'd2);

    // All requesters valid, no lock: rotation 1,2,3,0,1
    do_reset();
    base_tx = tx_q.size();
    req_data = 32'h1312_1110;
    req_valid = 4'hF;
    n = 0;
    while (tx_count != 16'd5 && n < 600) begin
      @(negedge clk);
      n++;
    end
    req_valid = '0;
    check("rr_txcnt", 32'(tx_count), 32'd5);
    check("rr_n", 32'(tx_q.size() - base_tx), 32'd5);
    if (tx_q.size() - base_tx >= 5) begin
      check("rr_0", 32'(tx_q[base_tx + 0]), 32'h11);
      check("rr_1", 32'(tx_q[base_tx + 1]), 32'h12);
      check("rr_2", 32'(tx_q[base_tx + 2]), 32'h13);
      check("rr_3", 32'(tx_q[base_tx + 3]), 32'h10);
      check("rr_4", 32'(tx_q[base_tx + 4]), 32'h11);
    end
    check("rr_pulse", 32'(pulse_viol), 32'd0);
    check("rr_grant", 32'(grant_id), 32'd1);

    // Requester 0 holds a 3-byte packet under lock while requester 1 waits
    @(negedge clk);
    base_tx = tx_q.size();
    req_data = 32'h0000_D1C0;
    req_lock = 4'b0001;
    req_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      wait_grant(4'b0001, "lock");
      @(negedge clk);
      req_data[7:0] = 8'hC1 + 8'(k);
      if (k == 2) begin
        req_lock = '0;
        req_valid = 4'b0010;
      end
    end
    wait_idle(1'b0, "lock");
    check("lock_release", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    wait_idle(1'b0, "lock_r1");
    check("lock_n", 32'(tx_q.size() - base_tx), 32'd4);
    if (tx_q.size() - base_tx >= 4) begin
      check("lock_0", 32'(tx_q[base_tx + 0]), 32'hC0);
      check("lock_1", 32'(tx_q[base_tx + 1]), 32'hC1);
      check("lock_2", 32'(tx_q[base_tx + 2]), 32'hC2);
      check("lock_3", 32'(tx_q[base_tx + 3]), 32'hD1);
    end
    check("lock_txcnt", 32'(tx_count), 32'd9);

    // Reset while a STATUS read is pending
    busy_until = status_reads + 1000;
    req_data[31:24] = 8'h77;
    req_valid = 4'b1000;
    wait_grant(4'b1000, "mid");
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (!(bus_req && !bus_wen) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_poll_pending", 32'(bus_req && !bus_wen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_bus_req", 32'(bus_req), 32'd0);
    check("mid_txcnt", 32'(tx_count), 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    base = log_q.size();
    base_tx = tx_q.size();
    busy_until = 0;
    @(negedge clk);
    rst = 1'b0;
    wait_idle(1'b0, "mid");
    check("mid_nacc", 32'(log_q.size() - base), 32'd1);
    if (log_q.size() > base) begin
      e = log_q[base];
      check("mid_first_wen", 32'(e[64]), 32'd1);
      check("mid_first_addr", e[63:32], BASE);
      check("mid_first_data", e[31:0], 32'h1);
    end
    check("mid_no_tx", 32'(tx_q.size() - base_tx), 32'd0);
    check("mid_grant", 32'(grant_id), 32'd0);

    check("bus_gap", 32'(gap_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
